// File: rtl/sfq_pulse_tx.sv
// Serialises a word into toggle-encoded SFQ data/clock pulse streams for a downstream DFFT.
// Define SFQ_TX_PARITY_EN to append an even-parity slot after the data bits.
module sfq_pulse_tx #(
    parameter int DATA_W    = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              a_out,
    output logic              clk_out,
    output logic              frame_done
);

`ifdef SFQ_TX_PARITY_EN
    localparam int N = DATA_W + 1;
`else
    localparam int N = DATA_W;
`endif
    localparam int SLOT_W = $clog2(N + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, DATA_PH, CLK_PH, GAP_PH} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      shift_q, shift_d;
    logic [N-1:0]      load_word;
    logic [N-1:0]      shift_next;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [3:0]        gap_q, gap_d;
    logic              a_out_q, a_out_d;
    logic              clk_out_q, clk_out_d;
    logic              frame_done_q, frame_done_d;
    logic              in_ready_q, in_ready_d;
    logic              cur_bit;

`ifdef SFQ_TX_PARITY_EN
    logic parity;
    assign parity = ^in_data;
    // Parity rides in the slot that is shifted out last in either bit order.
    assign load_word = MSB_FIRST ? {in_data, parity} : {parity, in_data};
`else
    assign load_word = in_data;
`endif

    assign cur_bit    = MSB_FIRST ? shift_q[N-1] : shift_q[0];
    assign shift_next = MSB_FIRST ? {shift_q[N-2:0], 1'b0} : {1'b0, shift_q[N-1:1]};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        slot_d       = slot_q;
        gap_d        = gap_q;
        a_out_d      = a_out_q;
        clk_out_d    = clk_out_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    shift_d = load_word;
                    slot_d  = '0;
                    state_d = DATA_PH;
                end
            end
            DATA_PH: begin
                if (cur_bit) begin
                    a_out_d = ~a_out_q;
                end
                state_d = CLK_PH;
            end
            CLK_PH: begin
                clk_out_d = ~clk_out_q;
                shift_d   = shift_next;
                if (slot_q == LAST_SLOT) begin
                    frame_done_d = 1'b1;
                    slot_d       = '0;
                    gap_d        = 4'd0;
                    state_d      = (GAP == 0) ? IDLE : GAP_PH;
                end else begin
                    slot_d  = slot_q + SLOT_W'(1);
                    state_d = DATA_PH;
                end
            end
            GAP_PH: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready tracks the state being entered, so it is low during reset.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            slot_q       <= '0;
            gap_q        <= 4'd0;
            a_out_q      <= 1'b0;
            clk_out_q    <= 1'b0;
            frame_done_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            slot_q       <= slot_d;
            gap_q        <= gap_d;
            a_out_q      <= a_out_d;
            clk_out_q    <= clk_out_d;
            frame_done_q <= frame_done_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign a_out      = a_out_q;
    assign clk_out    = clk_out_q;
    assign frame_done = frame_done_q;

endmodule
